// File: rtl/swipe_sequencer.sv
// Sequential "swipe" driver for the left/right turn-signal LED bars:
// fill inner-to-outer, hold fully lit, go dark, repeat while a mode is requested.
module swipe_sequencer #(
   parameter int unsigned LEDS       = 8,
   parameter int unsigned STEP_DIV   = 1350000,
   parameter int unsigned HOLD_STEPS = 4,
   parameter int unsigned OFF_STEPS  = 6
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            left,
   input  logic            right,
   input  logic            hazard,
   output logic [LEDS-1:0] led_left,
   output logic [LEDS-1:0] led_right,
   output logic            busy
);

   localparam int unsigned POS_W   = $clog2(LEDS + 1);
   localparam int unsigned PH_MAX  = (HOLD_STEPS > OFF_STEPS) ? HOLD_STEPS : OFF_STEPS;
   localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
   localparam int unsigned PRESC_W = $clog2(STEP_DIV + 1);

   typedef enum logic [1:0] {IDLE, SWIPE, HOLD, OFF} state_t;
   typedef enum logic [1:0] {M_NONE, M_LEFT, M_RIGHT, M_BOTH} mode_t;

   state_t               state_q, state_d;
   mode_t                amode_q, amode_d;
   mode_t                mode;
   logic [POS_W-1:0]     pos_q, pos_d;
   logic [PH_W-1:0]      phase_q, phase_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [LEDS-1:0]      led_left_q, led_left_d;
   logic [LEDS-1:0]      led_right_q, led_right_d;
   logic                 busy_q, busy_d;
   logic                 tick;
   logic [LEDS-1:0]      pattern;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         amode_q     <= M_NONE;
         pos_q       <= '0;
         phase_q     <= '0;
         presc_q     <= '0;
         led_left_q  <= '0;
         led_right_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         amode_q     <= amode_d;
         pos_q       <= pos_d;
         phase_q     <= phase_d;
         presc_q     <= presc_d;
         led_left_q  <= led_left_d;
         led_right_q <= led_right_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      if (hazard || (left && right)) mode = M_BOTH;
      else if (left)                 mode = M_LEFT;
      else if (right)                mode = M_RIGHT;
      else                           mode = M_NONE;
   end

   assign tick = (presc_q == PRESC_W'(STEP_DIV - 1));

   always_comb begin
      state_d = state_q;
      amode_d = amode_q;
      pos_d   = pos_q;
      phase_d = phase_q;
      presc_d = tick ? '0 : presc_q + 1'b1;

      case (state_q)
         IDLE: begin
            presc_d = '0;
            if (mode != M_NONE) begin
               state_d = SWIPE;
               amode_d = mode;
               pos_d   = POS_W'(1);
            end
         end
         default: begin
            // A different requested mode restarts at once, overriding any tick.
            if (mode != M_NONE && mode != amode_q) begin
               state_d = SWIPE;
               amode_d = mode;
               pos_d   = POS_W'(1);
               presc_d = '0;
            end else if (tick) begin
               case (state_q)
                  SWIPE: begin
                     if (pos_q == POS_W'(LEDS)) begin
                        state_d = HOLD;
                        phase_d = '0;
                     end else begin
                        pos_d = pos_q + 1'b1;
                     end
                  end
                  HOLD: begin
                     if (phase_q == PH_W'(HOLD_STEPS - 1)) begin
                        state_d = OFF;
                        phase_d = '0;
                     end else begin
                        phase_d = phase_q + 1'b1;
                     end
                  end
                  default: begin
                     if (phase_q == PH_W'(OFF_STEPS - 1)) begin
                        phase_d = '0;
                        if (mode != M_NONE) begin
                           state_d = SWIPE;
                           amode_d = mode;
                           pos_d   = POS_W'(1);
                        end else begin
                           state_d = IDLE;
                        end
                     end else begin
                        phase_d = phase_q + 1'b1;
                     end
                  end
               endcase
            end
         end
      endcase
   end

   // Outputs are encoded from next-state values so they register alongside the state.
   always_comb begin
      pattern = '0;
      if (state_d == SWIPE) begin
         for (int unsigned i = 0; i < LEDS; i++) begin
            pattern[i] = (i < 32'(pos_d));
         end
      end else if (state_d == HOLD) begin
         pattern = '1;
      end
      led_left_d  = (amode_d == M_LEFT  || amode_d == M_BOTH) ? pattern : '0;
      led_right_d = (amode_d == M_RIGHT || amode_d == M_BOTH) ? pattern : '0;
      busy_d      = (state_d != IDLE);
   end

   assign led_left  = led_left_q;
   assign led_right = led_right_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_swipe_sequencer.sv
// Directed bench for swipe_sequencer: elapsed-time model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_swipe_sequencer;

   localparam int LEDS   = 4;
   localparam int SD     = 3;
   localparam int HOLD   = 2;
   localparam int OFFS   = 2;
   localparam int PERIOD = (LEDS + HOLD + OFFS) * SD;

   logic            clk;
   logic            reset_n;
   logic            left, right, hazard;
   logic [LEDS-1:0] led_left, led_right;
   logic            busy;

   int n_checks = 0;
   int n_err    = 0;

   swipe_sequencer #(
      .LEDS      (LEDS),
      .STEP_DIV  (SD),
      .HOLD_STEPS(HOLD),
      .OFF_STEPS (OFFS)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .left     (left),
      .right    (right),
      .hazard   (hazard),
      .led_left (led_left),
      .led_right(led_right),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: cycles elapsed since the current cycle started, and the mode it runs in.
   // mode: 0 none, 1 left, 2 right, 3 both
   bit m_idle = 1'b1;
   int m_mode = 0;
   int m_k    = 0;

   function automatic int req_mode(logic l, logic r, logic h);
      if (h || (l && r)) return 3;
      if (l)             return 1;
      if (r)             return 2;
      return 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      int m;
      if (!reset_n) begin
         m_idle <= 1'b1;
         m_mode <= 0;
         m_k    <= 0;
      end else begin
         m = req_mode(left, right, hazard);
         if (m_idle) begin
            if (m != 0) begin
               m_idle <= 1'b0;
               m_mode <= m;
               m_k    <= 0;
            end
         end else if (m != 0 && m != m_mode) begin
            m_mode <= m;
            m_k    <= 0;
         end else if (m_k + 1 == PERIOD) begin
            if (m != 0) begin
               m_mode <= m;
               m_k    <= 0;
            end else begin
               m_idle <= 1'b1;
               m_k    <= 0;
            end
         end else begin
            m_k <= m_k + 1;
         end
      end
   end

   function automatic logic [LEDS-1:0] model_pattern(bit idle, int k);
      if (idle)                 return '0;
      if (k < LEDS * SD)        return LEDS'((1 << (k / SD + 1)) - 1);
      if (k < (LEDS + HOLD) * SD) return '1;
      return '0;
   endfunction

   always @(posedge clk) begin
      logic [LEDS-1:0] p;
      #1;
      p = model_pattern(m_idle, m_k);
      check("model_led_left",  32'(led_left),  32'((m_mode == 1 || m_mode == 3) ? p : '0));
      check("model_led_right", 32'(led_right), 32'((m_mode == 2 || m_mode == 3) ? p : '0));
      check("model_busy",      32'(busy),      32'(!m_idle));
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      left = 1'b0; right = 1'b0; hazard = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   logic [3:0] exp_left [0:24] = '{
      4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h7, 4'h7, 4'h7,
      4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
      4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1
   };

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1/2: reset with left held, then one full left period
      reset_n = 1'b0; left = 1'b1; right = 1'b0; hazard = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_led_left",  32'(led_left),  32'h0);
      check("rst_led_right", 32'(led_right), 32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         check("left_seq",       32'(led_left),  32'(exp_left[i]));
         check("left_seq_right", 32'(led_right), 32'h0);
      end

      // 3: right pulsed for a single cycle
      do_reset();
      right = 1'b1;
      @(negedge clk);
      right = 1'b0;
      check("rpulse_first", 32'(led_right), 32'h1);
      repeat (23) @(negedge clk);
      check("rpulse_busy_last", 32'(busy), 32'h1);
      @(negedge clk);
      check("rpulse_idle_busy", 32'(busy), 32'h0);
      check("rpulse_idle_led",  32'(led_right), 32'h0);
      repeat (5) @(negedge clk);
      check("rpulse_no_restart", 32'(busy), 32'h0);

      // 4: left running, switch to right at 0111, then to both
      do_reset();
      left = 1'b1;
      @(negedge clk);
      repeat (6) @(negedge clk);
      check("sw_pre_left", 32'(led_left), 32'h7);
      left = 1'b0; right = 1'b1;
      @(negedge clk);
      check("sw_right_left",  32'(led_left),  32'h0);
      check("sw_right_right", 32'(led_right), 32'h1);
      left = 1'b1;
      @(negedge clk);
      check("sw_both_left",  32'(led_left),  32'h1);
      check("sw_both_right", 32'(led_right), 32'h1);
      repeat (30) @(negedge clk);

      // 5: hazard, dropped during HOLD
      do_reset();
      hazard = 1'b1;
      @(negedge clk);
      repeat (10) @(negedge clk);
      hazard = 1'b0;
      repeat (7) @(negedge clk);
      check("hz_hold_left",  32'(led_left),  32'hF);
      check("hz_hold_right", 32'(led_right), 32'hF);
      @(negedge clk);
      check("hz_off_left", 32'(led_left), 32'h0);
      check("hz_off_busy", 32'(busy),     32'h1);
      repeat (6) @(negedge clk);
      check("hz_idle_busy", 32'(busy), 32'h0);
      repeat (3) @(negedge clk);

      // 6: asynchronous reset during HOLD
      do_reset();
      left = 1'b1;
      @(negedge clk);
      repeat (10) @(negedge clk);
      check("ar_hold", 32'(led_left), 32'hF);
      #2 reset_n = 1'b0;
      #1;
      check("ar_async_left", 32'(led_left), 32'h0);
      check("ar_async_busy", 32'(busy),     32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("ar_restart", 32'(led_left), 32'h1);
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
